// File: rtl/tile_net_adapter.sv
// ============================================================================
// tile_net_adapter : router-side adapter steering ejection packets to the tile
// cast/gather inputs, buffering tile output to injection, slicing merge chain.
// Optional statistics counters: define ADAPTER_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_net_adapter_slice #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] up_data_i,
   input  logic          up_valid_i,
   output logic          up_ready_o,
   output logic [DW-1:0] dn_data_o,
   output logic          dn_valid_o,
   input  logic          dn_ready_i
);
   logic          valid_q;
   logic [DW-1:0] data_q;

   assign up_ready_o = !valid_q || dn_ready_i;
   assign dn_valid_o = valid_q;
   assign dn_data_o  = data_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (up_valid_i && up_ready_o) begin
         valid_q <= 1'b1;
         data_q  <= up_data_i;
      end else if (dn_ready_i) begin
         valid_q <= 1'b0;
      end
   end
endmodule

module tile_net_adapter #(
   parameter int DW         = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] net_in_data,
   input  logic          net_in_valid,
   output logic          net_in_ready,
   output logic [DW-1:0] net_out_data,
   output logic          net_out_valid,
   input  logic          net_out_ready,
   output logic [DW-1:0] cast_data_i,
   output logic          cast_valid_i,
   input  logic          cast_ready_o,
   output logic [DW-1:0] gather_data_i,
   output logic          gather_valid_i,
   input  logic          gather_ready_o,
   input  logic [DW-1:0] cast_gather_data_o,
   input  logic          cast_gather_valid_o,
   output logic          cast_gather_ready_i,
   input  logic [DW-1:0] merge_data_o,
   input  logic          merge_valid_o,
   output logic          merge_ready_i,
   output logic [DW-1:0] merge_out_data,
   output logic          merge_out_valid,
   input  logic          merge_out_ready,
   input  logic [DW-1:0] merge_in_data,
   input  logic          merge_in_valid,
   output logic          merge_in_ready,
   output logic [DW-1:0] merge_data_i,
   output logic          merge_valid_i,
   input  logic          merge_ready_o,
   output logic          err_drop,
   output logic [15:0]   stat_cast_cnt,
   output logic [15:0]   stat_gather_cnt,
   output logic [15:0]   stat_drop_cnt
);
   localparam logic [1:0] C_HEAD   = 2'b01;
   localparam logic [1:0] C_TAIL   = 2'b10;
   localparam logic [1:0] C_SINGLE = 2'b11;
   localparam int         AW       = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CAST   = 2'd1,
      ST_GATHER = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] w_type;
   logic       w_is_hd;
   logic       w_route;
   logic       w_to_gather;
   logic       w_xfer;

   assign w_type        = net_in_data[DW-1:DW-2];
   assign w_is_hd       = (w_type == C_HEAD) || (w_type == C_SINGLE);
   assign cast_data_i   = net_in_data;
   assign gather_data_i = net_in_data;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      w_route        = 1'b0;
      w_to_gather    = 1'b0;
      w_xfer         = 1'b0;
      cast_valid_i   = 1'b0;
      gather_valid_i = 1'b0;
      net_in_ready   = 1'b0;
      err_drop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_is_hd) begin
               w_route     = 1'b1;
               w_to_gather = net_in_data[DW-3];
            end else begin
               // orphan body/tail: swallow it
               net_in_ready = 1'b1;
               err_drop     = net_in_valid;
            end
         end
         ST_CAST: begin
            w_route = 1'b1;
         end
         ST_GATHER: begin
            w_route     = 1'b1;
            w_to_gather = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (w_route) begin
         cast_valid_i   = net_in_valid && !w_to_gather;
         gather_valid_i = net_in_valid && w_to_gather;
         net_in_ready   = w_to_gather ? gather_ready_o : cast_ready_o;
         w_xfer         = net_in_valid && net_in_ready;
      end
      if (w_xfer) begin
         if (state_q == ST_IDLE) begin
            if (w_type == C_HEAD) state_d = w_to_gather ? ST_GATHER : ST_CAST;
         end else if (w_type == C_TAIL) begin
            state_d = ST_IDLE;
         end else if (w_is_hd) begin
            err_drop = 1'b1;
         end
      end
      // valids must drop the instant reset is asserted
      if (!rstn) begin
         cast_valid_i   = 1'b0;
         gather_valid_i = 1'b0;
         err_drop       = 1'b0;
      end
   end

   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic          w_full, w_empty, w_wr, w_rd;

   assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign cast_gather_ready_i = !w_full;
   assign net_out_valid       = !w_empty;
   assign net_out_data        = mem_q[rd_ptr_q[AW-1:0]];
   assign w_wr = cast_gather_valid_o && !w_full;
   assign w_rd = net_out_ready && !w_empty;

   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q[AW-1:0]] <= cast_gather_data_o;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (w_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   tile_net_adapter_slice #(.DW(DW)) u_slice_down (
      .clk        (clk),
      .rstn       (rstn),
      .up_data_i  (merge_data_o),
      .up_valid_i (merge_valid_o),
      .up_ready_o (merge_ready_i),
      .dn_data_o  (merge_out_data),
      .dn_valid_o (merge_out_valid),
      .dn_ready_i (merge_out_ready)
   );

   tile_net_adapter_slice #(.DW(DW)) u_slice_up (
      .clk        (clk),
      .rstn       (rstn),
      .up_data_i  (merge_in_data),
      .up_valid_i (merge_in_valid),
      .up_ready_o (merge_in_ready),
      .dn_data_o  (merge_data_i),
      .dn_valid_o (merge_valid_i),
      .dn_ready_i (merge_ready_o)
   );

`ifdef ADAPTER_STATS_EN
   logic [15:0] cast_cnt_q, gather_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cast_cnt_q   <= '0;
         gather_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         if (cast_valid_i && cast_ready_o)     cast_cnt_q   <= cast_cnt_q + 16'd1;
         if (gather_valid_i && gather_ready_o) gather_cnt_q <= gather_cnt_q + 16'd1;
         if (err_drop)                         drop_cnt_q   <= drop_cnt_q + 16'd1;
      end
   end

   assign stat_cast_cnt   = cast_cnt_q;
   assign stat_gather_cnt = gather_cnt_q;
   assign stat_drop_cnt   = drop_cnt_q;
`else
   assign stat_cast_cnt   = '0;
   assign stat_gather_cnt = '0;
   assign stat_drop_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_net_adapter.sv
// ============================================================================
// tb_tile_net_adapter : directed self-checking bench for tile_net_adapter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_net_adapter;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] net_in_data, net_out_data, cast_data_i, gather_data_i;
   logic          net_in_valid, net_in_ready, net_out_valid, net_out_ready;
   logic          cast_valid_i, cast_ready_o, gather_valid_i, gather_ready_o;
   logic [DW-1:0] cast_gather_data_o, merge_data_o, merge_out_data, merge_in_data, merge_data_i;
   logic          cast_gather_valid_o, cast_gather_ready_i;
   logic          merge_valid_o, merge_ready_i, merge_out_valid, merge_out_ready;
   logic          merge_in_valid, merge_in_ready, merge_valid_i, merge_ready_o;
   logic          err_drop;
   logic [15:0]   stat_cast_cnt, stat_gather_cnt, stat_drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_net_adapter #(.DW(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .net_in_data(net_in_data), .net_in_valid(net_in_valid), .net_in_ready(net_in_ready),
      .net_out_data(net_out_data), .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
      .cast_data_i(cast_data_i), .cast_valid_i(cast_valid_i), .cast_ready_o(cast_ready_o),
      .gather_data_i(gather_data_i), .gather_valid_i(gather_valid_i), .gather_ready_o(gather_ready_o),
      .cast_gather_data_o(cast_gather_data_o), .cast_gather_valid_o(cast_gather_valid_o),
      .cast_gather_ready_i(cast_gather_ready_i),
      .merge_data_o(merge_data_o), .merge_valid_o(merge_valid_o), .merge_ready_i(merge_ready_i),
      .merge_out_data(merge_out_data), .merge_out_valid(merge_out_valid), .merge_out_ready(merge_out_ready),
      .merge_in_data(merge_in_data), .merge_in_valid(merge_in_valid), .merge_in_ready(merge_in_ready),
      .merge_data_i(merge_data_i), .merge_valid_i(merge_valid_i), .merge_ready_o(merge_ready_o),
      .err_drop(err_drop),
      .stat_cast_cnt(stat_cast_cnt), .stat_gather_cnt(stat_gather_cnt), .stat_drop_cnt(stat_drop_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] flit(input logic [1:0] ty, input logic ch, input int pl);
      flit = {ty, ch, 61'(pl)};
   endfunction

   // inbound vector: flit type, channel bit, valid, readies, expected {cv,gv,rdy,err}
   typedef struct packed {
      logic [1:0] ty;
      logic       ch;
      logic       v;
      logic       cr;
      logic       gr;
      logic [3:0] exp;
   } vec_t;

   vec_t          vt [17];
   logic [DW-1:0] dq [5];

   initial begin
      int acc, rc, sent, c;
      logic [DW-1:0] d;

      vt[0]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010}; // head cast -> CAST
      vt[1]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010}; // body follows lock
      vt[2]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010}; // tail -> IDLE
      vt[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110}; // single gather
      vt[4]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000}; // head cast, stalled
      vt[5]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010}; // head cast -> CAST
      vt[6]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011}; // single in CAST: error, stays cast
      vt[7]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010}; // no valid
      vt[8]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000}; // tail stalled
      vt[9]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010}; // tail -> IDLE
      vt[10] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011}; // orphan body
      vt[11] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010}; // idle tail, no valid
      vt[12] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110}; // head gather -> GATHER
      vt[13] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0111}; // head in GATHER: error
      vt[14] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100}; // tail stalled on gather
      vt[15] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110}; // tail -> IDLE
      vt[16] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010}; // single cast
      for (int k = 0; k < 5; k++) dq[k] = 64'hA5A5_0000_0000_0000 | 64'(k);

      rstn = 1'b0;
      net_in_data = '0; net_in_valid = 0; cast_ready_o = 1; gather_ready_o = 1;
      net_out_ready = 0; cast_gather_data_o = '0; cast_gather_valid_o = 0;
      merge_data_o = '0; merge_valid_o = 0; merge_out_ready = 1;
      merge_in_data = '0; merge_in_valid = 0; merge_ready_o = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {cast_valid_i, gather_valid_i, net_out_valid, merge_out_valid, merge_valid_i}, 0);
      chk("rst_err", err_drop, 0);
      chk("rst_readies", {cast_gather_ready_i, merge_ready_i, merge_in_ready}, 3'b111);
      chk("rst_stats", {stat_cast_cnt, stat_gather_cnt, stat_drop_cnt}, 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         d = flit(vt[i].ty, vt[i].ch, 100 + i);
         net_in_data = d; net_in_valid = vt[i].v;
         cast_ready_o = vt[i].cr; gather_ready_o = vt[i].gr;
         #3;
         chk($sformatf("inb_v%0d", i), {cast_valid_i, gather_valid_i, net_in_ready, err_drop}, vt[i].exp);
         if (vt[i].exp[3]) chk($sformatf("inb_cdata%0d", i), cast_data_i, d);
         if (vt[i].exp[2]) chk($sformatf("inb_gdata%0d", i), gather_data_i, d);
         @(posedge clk); #1;
      end
      net_in_valid = 0; cast_ready_o = 1; gather_ready_o = 1;
`ifdef ADAPTER_STATS_EN
      chk("stats", {stat_cast_cnt, stat_gather_cnt, stat_drop_cnt}, {16'd7, 16'd4, 16'd3});
`else
      chk("stats_off", {stat_cast_cnt, stat_gather_cnt, stat_drop_cnt}, 0);
`endif

      // outbound fill with injection blocked
      acc = 0;
      chk("ob_empty", net_out_valid, 0);
      for (c = 0; c < 10 && acc < 4; c++) begin
         cast_gather_valid_o = 1; cast_gather_data_o = dq[acc];
         @(negedge clk);
         if (cast_gather_ready_i) acc++;
         @(posedge clk); #1;
         if (c == 0) chk("ob_latency", net_out_valid, 1);
      end
      cast_gather_data_o = dq[acc];
      @(negedge clk);
      chk("ob_accepted", acc, 4);
      chk("ob_full_ready", cast_gather_ready_i, 0);
      chk("ob_head", net_out_data, dq[0]);
      @(posedge clk); #1;
      net_out_ready = 1; rc = 0;
      for (c = 0; c < 30 && rc < 5; c++) begin
         cast_gather_valid_o = (acc < 5);
         cast_gather_data_o  = dq[acc < 5 ? acc : 4];
         @(negedge clk);
         if (net_out_valid && net_out_ready) begin
            chk($sformatf("ob_order%0d", rc), net_out_data, dq[rc]);
            rc++;
         end
         if (cast_gather_valid_o && cast_gather_ready_i) acc++;
         @(posedge clk); #1;
      end
      chk("ob_drained", rc, 5);
      cast_gather_valid_o = 0; net_out_ready = 0;

      // merge downstream slice with 3 stalled cycles
      sent = 0; rc = 0;
      for (c = 0; c < 20 && rc < 4; c++) begin
         merge_valid_o = (sent < 4); merge_data_o = 64'hBEEF_0000 + 64'(sent < 4 ? sent : 3);
         merge_out_ready = (c >= 3);
         @(negedge clk);
         if (c == 0) chk("mg_ready_c0", merge_ready_i, 1);
         if (c == 1 || c == 2) chk($sformatf("mg_ready_c%0d", c), merge_ready_i, 0);
         if (merge_out_valid && merge_out_ready) begin
            chk($sformatf("mg_order%0d", rc), merge_out_data, 64'hBEEF_0000 + 64'(rc));
            rc++;
         end
         if (merge_valid_o && merge_ready_i) sent++;
         @(posedge clk); #1;
      end
      chk("mg_count", rc, 4);
      merge_valid_o = 0; merge_out_ready = 1;

      // merge upstream slice with alternating tile readiness
      sent = 0; rc = 0;
      for (c = 0; c < 20 && rc < 4; c++) begin
         merge_in_valid = (sent < 4); merge_in_data = 64'hC0DE_0000 + 64'(sent < 4 ? sent : 3);
         merge_ready_o = (c % 2 == 1);
         @(negedge clk);
         if (merge_valid_i && merge_ready_o) begin
            chk($sformatf("mi_order%0d", rc), merge_data_i, 64'hC0DE_0000 + 64'(rc));
            rc++;
         end
         if (merge_in_valid && merge_in_ready) sent++;
         @(posedge clk); #1;
      end
      chk("mi_count", rc, 4);
      merge_in_valid = 0; merge_ready_o = 1;

      // reset mid-packet with FIFO and slice occupied
      net_in_data = flit(2'b01, 1'b0, 7); net_in_valid = 1;
      cast_gather_valid_o = 1; cast_gather_data_o = dq[1];
      merge_valid_o = 1; merge_data_o = 64'h1234; merge_out_ready = 0;
      @(posedge clk); #1;
      cast_gather_valid_o = 0; merge_valid_o = 0;
      net_in_data = flit(2'b00, 1'b1, 8);
      #1;
      chk("rs_locked", {cast_valid_i, gather_valid_i, net_out_valid, merge_out_valid}, 4'b1011);
      #1 rstn = 1'b0;
      #1;
      chk("rs_valids", {cast_valid_i, gather_valid_i, net_out_valid, merge_out_valid, merge_valid_i}, 0);
      chk("rs_ready", cast_gather_ready_i, 1);
      @(negedge clk);
      rstn = 1'b1;
      net_in_data = flit(2'b10, 1'b0, 9);
      #1;
      chk("rs_orphan", {cast_valid_i, gather_valid_i, net_in_ready, err_drop}, 4'b0011);
      @(posedge clk); #1;
      net_in_valid = 0;
      #1;
      chk("rs_err_pulse", err_drop, 0);
`ifdef ADAPTER_STATS_EN
      chk("rs_stat_drop", stat_drop_cnt, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
